// File: rtl/ips2l_pcie_dma_wr_ctrl.sv
// rtl/ips2l_pcie_dma_wr_ctrl.sv - write-side DMA payload realign and BAR RAM write controller
// Purpose: accepts DW-packed 128-bit TLP payload beats, shifts them to the RAM DW offset
//   given by i_wr_addr[3:2] and writes them into the BAR RAM with per-byte enables.
// Ports:
//   clk, rst                  core clock, asynchronous active-high reset
//   i_wr_en                   rising edge starts a transfer
//   i_wr_length, i_wr_addr    payload length in DW (0 = 1024), byte start address
//   i_wr_data/_vld/_last      payload beat stream; o_wr_data_ready accepts a beat
//   o_wr_busy, o_wr_done      transfer in progress, 1-cycle completion pulse
//   o_len_err                 sticky last-marker mismatch (cleared at next start)
//   o_bar_wr_en/_addr/_data/_be  registered BAR RAM write port
// Optional feature: define DMA_WR_LEN_CHK_EN to check i_wr_data_last against the length.
module ips2l_pcie_dma_wr_ctrl #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [9:0]            i_wr_length,
  input  logic [63:0]           i_wr_addr,
  input  logic [127:0]          i_wr_data,
  input  logic                  i_wr_data_vld,
  input  logic                  i_wr_data_last,
  output logic                  o_wr_data_ready,
  output logic                  o_wr_busy,
  output logic                  o_wr_done,
  output logic                  o_len_err,
  output logic                  o_bar_wr_en,
  output logic [ADDR_WIDTH-1:0] o_bar_wr_addr,
  output logic [127:0]          o_bar_wr_data,
  output logic [15:0]           o_bar_wr_be
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FLUSH, S_DONE} state_t;

  state_t                r_state;
  logic                  r_wr_en_d;
  logic [1:0]            r_pos;
  logic [1:0]            r_rem;
  logic [8:0]            r_in_beats;
  logic [8:0]            r_out_beats;
  logic [8:0]            r_in_cnt;
  logic [8:0]            r_wr_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [127:0]          r_residue;

  logic [10:0]  w_len;
  logic [1:0]   w_pos;
  logic [10:0]  w_in_sum;
  logic [10:0]  w_out_sum;
  logic [1:0]   w_rem;
  logic         w_start;
  logic         w_acc;
  logic         w_last_in;
  logic         w_first_wr;
  logic         w_last_wr;
  logic [127:0] w_shl;
  logic [127:0] w_res_n;
  logic [15:0]  w_first_mask;
  logic [15:0]  w_last_mask;
  logic [15:0]  w_be;
  logic         w_unused;

  // Length 0 encodes 1024 DW; all count arithmetic is 11 bits wide so 1024+3+3 cannot overflow.
  assign w_len     = (i_wr_length == 10'd0) ? 11'h400 : {1'b0, i_wr_length};
  assign w_pos     = i_wr_addr[3:2];
  assign w_in_sum  = w_len + 11'd3;
  assign w_out_sum = w_len + {9'd0, w_pos} + 11'd3;
  assign w_rem     = w_len[1:0] + w_pos;

  assign w_start    = (r_state == S_IDLE) && i_wr_en && !r_wr_en_d;
  assign w_acc      = i_wr_data_vld && o_wr_data_ready;
  assign w_last_in  = (r_in_cnt == r_in_beats - 9'd1);
  assign w_first_wr = (r_wr_cnt == 9'd0);
  assign w_last_wr  = (r_wr_cnt == r_out_beats - 9'd1);

  // Lanes shifted past lane 3 are carried as residue into the next RAM word.
  always_comb begin
    w_shl   = i_wr_data;
    w_res_n = 128'd0;
    case (r_pos)
      2'd1: begin
        w_shl   = {i_wr_data[95:0], 32'd0};
        w_res_n = {96'd0, i_wr_data[127:96]};
      end
      2'd2: begin
        w_shl   = {i_wr_data[63:0], 64'd0};
        w_res_n = {64'd0, i_wr_data[127:64]};
      end
      2'd3: begin
        w_shl   = {i_wr_data[31:0], 96'd0};
        w_res_n = {32'd0, i_wr_data[127:32]};
      end
      default: begin
        w_shl   = i_wr_data;
        w_res_n = 128'd0;
      end
    endcase
  end

  always_comb begin
    w_first_mask = 16'hFFFF;
    case (r_pos)
      2'd1:    w_first_mask = 16'hFFF0;
      2'd2:    w_first_mask = 16'hFF00;
      2'd3:    w_first_mask = 16'hF000;
      default: w_first_mask = 16'hFFFF;
    endcase
    w_last_mask = 16'hFFFF;
    case (r_rem)
      2'd1:    w_last_mask = 16'h000F;
      2'd2:    w_last_mask = 16'h00FF;
      2'd3:    w_last_mask = 16'h0FFF;
      default: w_last_mask = 16'hFFFF;
    endcase
    w_be = (w_first_wr ? w_first_mask : 16'hFFFF) & (w_last_wr ? w_last_mask : 16'hFFFF);
  end

`ifdef DMA_WR_LEN_CHK_EN
  assign w_unused = ^{i_wr_addr[63:ADDR_WIDTH+4], i_wr_addr[1:0]};
`else
  assign w_unused = ^{i_wr_addr[63:ADDR_WIDTH+4], i_wr_addr[1:0], i_wr_data_last};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_wr_en_d       <= 1'b0;
      r_pos           <= 2'd0;
      r_rem           <= 2'd0;
      r_in_beats      <= 9'd0;
      r_out_beats     <= 9'd0;
      r_in_cnt        <= 9'd0;
      r_wr_cnt        <= 9'd0;
      r_addr          <= '0;
      r_residue       <= 128'd0;
      o_wr_data_ready <= 1'b0;
      o_wr_busy       <= 1'b0;
      o_wr_done       <= 1'b0;
      o_len_err       <= 1'b0;
      o_bar_wr_en     <= 1'b0;
      o_bar_wr_addr   <= '0;
      o_bar_wr_data   <= 128'd0;
      o_bar_wr_be     <= 16'd0;
    end else begin
      r_wr_en_d   <= i_wr_en;
      o_bar_wr_en <= 1'b0;
      o_wr_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_pos           <= w_pos;
            r_rem           <= w_rem;
            r_in_beats      <= w_in_sum[10:2];
            r_out_beats     <= w_out_sum[10:2];
            r_in_cnt        <= 9'd0;
            r_wr_cnt        <= 9'd0;
            r_addr          <= i_wr_addr[ADDR_WIDTH+3:4];
            r_residue       <= 128'd0;
            o_len_err       <= 1'b0;
            o_wr_data_ready <= 1'b1;
            o_wr_busy       <= 1'b1;
            r_state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_acc) begin
            o_bar_wr_en   <= 1'b1;
            o_bar_wr_addr <= r_addr;
            o_bar_wr_data <= w_shl | r_residue;
            o_bar_wr_be   <= w_be;
            r_addr        <= r_addr + 1'b1;
            r_wr_cnt      <= r_wr_cnt + 9'd1;
            r_in_cnt      <= r_in_cnt + 9'd1;
            r_residue     <= w_res_n;
`ifdef DMA_WR_LEN_CHK_EN
            if (i_wr_data_last != w_last_in) begin
              o_len_err <= 1'b1;
            end
`endif
            if (w_last_in) begin
              o_wr_data_ready <= 1'b0;
              r_state         <= (r_out_beats > r_in_beats) ? S_FLUSH : S_DONE;
            end
          end
        end
        S_FLUSH: begin
          // Trailing lanes of the final input beat spill into one extra RAM word.
          o_bar_wr_en   <= 1'b1;
          o_bar_wr_addr <= r_addr;
          o_bar_wr_data <= r_residue;
          o_bar_wr_be   <= w_be;
          r_addr        <= r_addr + 1'b1;
          r_wr_cnt      <= r_wr_cnt + 9'd1;
          r_state       <= S_DONE;
        end
        default: begin
          o_wr_done <= 1'b1;
          o_wr_busy <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
